// File: rtl/formal_imem_responder.sv
// formal_imem_responder: instruction memory model that sequences core boot
// (reset, one flush cycle) and then serves fetches/stores from a small table.
module formal_imem_responder #(
    parameter int DEPTH = 8,
    parameter int ADDR_LSB = 2,
    parameter int LATENCY = 1,
    parameter int BOOT_CYCLES = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic clock,
    input  logic reset_n,
    output logic core_reset,
    input  logic req_valid,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0] req_mask,
    output logic resp_valid,
    output logic [31:0] resp_data,
    input  logic load_en,
    input  logic [IW-1:0] load_idx,
    input  logic [31:0] load_data,
    output logic oob_err,
    output logic [15:0] resp_count
);
    typedef enum logic [1:0] {BOOT, FLUSH, IDLE, WAIT} state_t;
    state_t state, next_state;
    logic [3:0] boot_cnt;
    logic [2:0] lat_cnt;
    logic [31:0] mem [DEPTH];
    logic [31:0] pend_data, shifted, rd_word, merged;
    logic [IW-1:0] idx;
    logic oob, accept, issue;
    assign shifted = req_addr >> ADDR_LSB;
    assign idx = shifted[IW-1:0];
    assign oob = |(shifted >> IW);
    assign accept = state == IDLE && req_valid;
    assign issue = (accept && LATENCY == 1) || (state == WAIT && lat_cnt == 3'd1);
    // Stores answer 0; out-of-range reads answer the NOP word.
    assign rd_word = |req_mask ? '0 : oob ? NOP_INST : mem[idx];
    always_comb begin
        merged = mem[idx];
        for (int b = 0; b < 4; b++)
            if (req_mask[b]) merged[8*b +: 8] = req_data[8*b +: 8];
    end
    always_ff @(posedge clock)
        state <= !reset_n ? BOOT : next_state;
    always_comb
        next_state = state == BOOT  ? (boot_cnt == 4'(BOOT_CYCLES - 1) ? FLUSH : BOOT) :
                     state == FLUSH ? IDLE :
                     state == IDLE  ? (accept && LATENCY > 1 ? WAIT : IDLE) :
                     (lat_cnt == 3'd1 ? IDLE : WAIT);
    always_comb
        core_reset = state == BOOT;
    // A load issued after the store in the same edge, so it takes precedence.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_INST;
        end else begin
            if (accept && |req_mask && !oob) mem[idx] <= merged;
            if (load_en) mem[load_idx] <= load_data;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            boot_cnt <= '0;
            lat_cnt <= '0;
            pend_data <= '0;
            resp_valid <= 1'b0;
            resp_data <= '0;
            oob_err <= 1'b0;
            resp_count <= '0;
        end else begin
            boot_cnt <= state == BOOT ? boot_cnt + 4'd1 : '0;
            resp_valid <= issue;
            if (issue) resp_data <= accept ? rd_word : pend_data;
            if (issue && resp_count != 16'hFFFF) resp_count <= resp_count + 16'd1;
            if (accept) begin
                lat_cnt <= 3'(LATENCY - 1);
                pend_data <= rd_word;
                oob_err <= oob_err | oob;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_formal_imem_responder.sv
// tb_formal_imem_responder: two responders (latency 1 and 3) on shared stimulus,
// each compared every cycle against a timestamp-based reference model.
module tb_formal_imem_responder;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset_n = 1'b0, req_valid = 1'b0, load_en = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0, load_data = '0;
    logic [3:0] req_mask = '0;
    logic [2:0] load_idx = '0;
    logic [1:0] core_reset, resp_valid, oob_err;
    logic [1:0][31:0] resp_data;
    logic [1:0][15:0] resp_count;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        formal_imem_responder #(.LATENCY(g == 0 ? 1 : 3)) dut (
            .clock(clock), .reset_n(reset_n), .core_reset(core_reset[g]),
            .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
            .req_mask(req_mask), .resp_valid(resp_valid[g]), .resp_data(resp_data[g]),
            .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
            .oob_err(oob_err[g]), .resp_count(resp_count[g])
        );
    end
    int lat [2] = '{1, 3};
    int t [2], free_t [2], resp_at [2], exp_cnt [2];
    logic [31:0] pend [2], exp_data [2];
    logic [31:0] mem [2][8];
    bit exp_oob [2], exp_valid [2];
    int n_checks = 0, n_fail = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Reference: edges since reset decide boot phase; a request occupies the
    // responder for lat edges and its answer appears exactly lat edges later.
    task automatic model_edge(input int k);
        int idx;
        bit oob;
        logic [31:0] rd;
        exp_valid[k] = 0;
        if (!reset_n) begin
            t[k] = 0; free_t[k] = 0; resp_at[k] = -1;
            exp_data[k] = '0; exp_cnt[k] = 0; exp_oob[k] = 0;
            for (int i = 0; i < 8; i++) mem[k][i] = NOP;
            return;
        end
        if (req_valid && t[k] > 2 && t[k] >= free_t[k]) begin
            idx = int'((req_addr >> 2) & 32'd7);
            oob = (req_addr >> 5) != 0;
            rd = req_mask != 0 ? 32'd0 : oob ? NOP : mem[k][idx];
            if (req_mask != 0 && !oob)
                for (int b = 0; b < 4; b++)
                    if (req_mask[b]) mem[k][idx][8*b +: 8] = req_data[8*b +: 8];
            if (oob) exp_oob[k] = 1;
            free_t[k] = t[k] + lat[k];
            resp_at[k] = t[k] + lat[k];
            pend[k] = rd;
        end
        if (load_en) mem[k][load_idx] = load_data;
        t[k]++;
        if (t[k] == resp_at[k]) begin
            exp_valid[k] = 1;
            exp_data[k] = pend[k];
            if (exp_cnt[k] < 65535) exp_cnt[k]++;
        end
    endtask
    task automatic step();
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("L%0d core_reset", lat[k]), 32'(core_reset[k]), 32'(t[k] < 2));
            check($sformatf("L%0d resp_valid", lat[k]), 32'(resp_valid[k]), 32'(exp_valid[k]));
            check($sformatf("L%0d resp_data", lat[k]), resp_data[k], exp_data[k]);
            check($sformatf("L%0d oob_err", lat[k]), 32'(oob_err[k]), 32'(exp_oob[k]));
            check($sformatf("L%0d resp_count", lat[k]), 32'(resp_count[k]), 32'(exp_cnt[k]));
        end
    endtask
    task automatic boot();
        req_valid = 0; load_en = 0; reset_n = 0;
        step(); step();
        reset_n = 1;
        step(); step(); step();
    endtask
    task automatic idle(input int n);
        req_valid = 0; load_en = 0;
        for (int i = 0; i < n; i++) step();
    endtask
    initial begin
        boot();
        check("boot done core_reset", 32'(core_reset[0]), 32'd0);
        load_en = 1; load_idx = 3; load_data = 32'h0c860613;
        step();
        load_en = 0; req_valid = 1; req_addr = 32'hC; req_mask = 0;
        step();
        req_valid = 0;
        check("read data", resp_data[0], 32'h0c860613);
        check("read count", 32'(resp_count[0]), 32'd1);
        idle(4);
        req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'(4 * i);
            step();
            check("b2b valid", 32'(resp_valid[0]), 32'd1);
            check("b2b data", resp_data[0], i == 3 ? 32'h0c860613 : NOP);
        end
        idle(6);
        load_en = 1; load_idx = 1; load_data = 32'h11223344;
        step();
        load_en = 0; req_valid = 1; req_addr = 32'h4; req_data = 32'hAABBCCDD; req_mask = 4'b0101;
        step();
        check("store data", resp_data[0], 32'd0);
        req_mask = 0;
        step();
        req_valid = 0;
        check("merged read", resp_data[0], 32'h11BB33DD);
        idle(4);
        req_valid = 1; req_addr = 32'h20;
        step();
        check("oob data", resp_data[0], NOP);
        check("oob flag", 32'(oob_err[0]), 32'd1);
        req_addr = 32'h0;
        step();
        req_valid = 0;
        check("oob sticky", 32'(oob_err[0]), 32'd1);
        idle(4);
        for (int i = 0; i < 500; i++) begin
            reset_n = $urandom_range(0, 99) != 0;
            req_valid = $urandom_range(0, 1) == 1;
            req_addr = $urandom_range(0, 4) == 0 ? $urandom : 32'($urandom_range(0, 31));
            req_data = $urandom;
            req_mask = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom);
            load_en = $urandom_range(0, 3) == 0;
            load_idx = 3'($urandom);
            load_data = $urandom;
            step();
        end
        reset_n = 1;
        boot();
        req_valid = 1; req_addr = 32'h8; req_mask = 0;
        step();
        req_valid = 0;
        step();
        reset_n = 0;
        step();
        check("cancel resp_valid", 32'(resp_valid[1]), 32'd0);
        check("cancel core_reset", 32'(core_reset[1]), 32'd1);
        reset_n = 1;
        step(); step(); step();
        req_valid = 1; req_addr = 32'hC;
        step();
        req_valid = 0;
        check("table reset", resp_data[0], NOP);
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
